// File: rtl/crane_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package crane_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StError
  } loader_state_e;

  function automatic logic [WORD_W-1:0] word_to_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes little-endian into a 32-bit word; word_full_o flags the 4th byte of each word.
module byte_packer
  import crane_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load_i) begin
      word_d[BYTE_W*idx_q +: BYTE_W] = byte_i;
      idx_d = idx_q + 2'd1;
    end
  end

  // Word output includes the byte being loaded so the top can latch it on the same edge.
  assign word_o      = word_d;
  assign word_full_o = load_i & ~clr_i & (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream (length, payload, XOR checksum) to instruction memory writes.
module imem_loader
  import crane_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [WORD_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  localparam int unsigned    IdleW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IdleW:0] TimeoutCnt = TIMEOUT[IdleW:0];

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;

  logic              accept;
  logic              in_frame;
  logic              pk_clr;
  logic              pk_load;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;
  logic [15:0]       len_hdr;
  logic [IdleW:0]    idle_next;

  assign accept    = rx_valid & rx_ready_q;
  assign in_frame  = state_q inside {StLenLo, StLenHi, StData, StCsum};
  assign pk_load   = accept & (state_q == StData);
  assign len_hdr   = {rx_data, len_q[7:0]};
  assign idle_next = {1'b0, idle_q} + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (pk_clr),
    .load_i     (pk_load),
    .byte_i     (rx_data),
    .word_o     (pk_word),
    .word_full_o(pk_full)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    idle_d      = idle_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    we_d        = 1'b0;
    pk_clr      = 1'b0;

    if (in_frame) begin
      idle_d = accept ? '0 : idle_next[IdleW-1:0];
    end

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d     = StLenLo;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_rst_n_d = 1'b0;
          len_d       = '0;
          word_idx_d  = '0;
          csum_d      = '0;
          idle_d      = '0;
          pk_clr      = 1'b1;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = len_hdr;
          if ({16'd0, len_hdr} > DEPTH) begin
            state_d = StError;
          end else if (len_hdr == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
        end
        if (pk_full) begin
          we_d       = 1'b1;
          wdata_d    = pk_word;
          waddr_d    = word_to_byte_addr(word_idx_q);
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_q == len_q - 16'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase

    // An expiring idle count never coincides with a write: pk_full needs an accepted byte.
    if ((TIMEOUT != 0) && in_frame && !accept && (idle_next == TimeoutCnt)) begin
      state_d = StError;
    end

    if (state_d == StError) begin
      err_d       = 1'b1;
      done_d      = 1'b0;
      cpu_rst_n_d = 1'b0;
    end else if (state_d == StDone) begin
      done_d      = 1'b1;
      cpu_rst_n_d = 1'b1;
    end

    rx_ready_d = state_d inside {StLenLo, StLenHi, StData, StCsum};
    busy_d     = rx_ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_idx_q  <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length bounds, timeout and mid-load reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH  (32),
    .TIMEOUT(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_rst_n(cpu_rst_n)
  );

  // Each cycle with we high is logged as one write.
  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Entered #1 after an edge; returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) begin
      check("rx_ready_wait", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, wr_data[0], 32'h0010_0093);
      check({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, wr_data[1], 32'h0020_0113);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Good two-word frame; XOR of the payload bytes is 0xB1.
    clear_log();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
    send_frame();
    check_status("good", 1'b1, 1'b0, 1'b1);
    check_two_writes("good");

    // Same payload, wrong checksum: writes still land, load fails.
    clear_log();
    pulse_start();
    check("restart_done_cleared", 32'(done), 32'd0);
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'h24};
    send_frame();
    check_status("badcsum", 1'b0, 1'b1, 1'b0);
    check_two_writes("badcsum");

    // Length 33 exceeds DEPTH.
    clear_log();
    pulse_start();
    frame = '{8'h21, 8'h00};
    send_frame();
    check_status("len33", 1'b0, 1'b1, 1'b0);
    check("len33_nwr", 32'(wr_addr.size()), 32'd0);

    // Length 32 is the largest accepted length.
    clear_log();
    pulse_start();
    frame = '{8'h20, 8'h00};
    send_frame();
    @(negedge clk);
    check("len32_busy", 32'(busy), 32'd1);
    check("len32_err", 32'(err), 32'd0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // Empty frames.
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame();
    check_status("len0_ok", 1'b1, 1'b0, 1'b1);
    check("len0_ok_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h01};
    send_frame();
    check_status("len0_bad", 1'b0, 1'b1, 1'b0);

    // Stall mid-word beyond the idle limit.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_frame();
    repeat (11) @(posedge clk);
    check_status("timeout", 1'b0, 1'b1, 1'b0);
    check("timeout_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
    send_frame();
    check_status("after_timeout", 1'b1, 1'b0, 1'b1);
    check_two_writes("after_timeout");

    // Reset while the first write strobe is pending.
    clear_log();
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame();
    check("pre_rst_we", 32'(we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rx_ready", 32'(rx_ready), 32'd0);
    check("async_rst_waddr", waddr, 32'd0);
    check("async_rst_wdata", wdata, 32'd0);
    check("async_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("async_rst_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'hB1};
    send_frame();
    check_status("after_rst", 1'b1, 1'b0, 1'b1);
    check_two_writes("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
